tage_update_scheduler: RTL and testbench

- Collects resolved-branch predictor updates from NUM_PORTS branch units and queues them in a QUEUE_SIZE-entry FIFO.
- Drains the FIFO into the TAGE predictor's single write port at one update per cycle.
- Periodically pauses draining to run a useful-bit aging sweep over every TAGE table index.
- Sits between branch resolution and the TAGE predictor; it owns all predictor write traffic.

---
 rtl/tage_update_scheduler.sv | 163 ++++++++++++++++
 tb/tb_tage_update_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tage_update_scheduler.sv
// Queues resolved-branch updates and drains one per cycle into the TAGE write port; writes register 1 cycle after enqueue.
// OUT_brStall backpressures the branch units; every AGE_PERIOD writes draining pauses for a TABLE_SIZE-cycle aging sweep.
module tage_update_scheduler #(
  parameter int NUM_PORTS  = 2,
  parameter int QUEUE_SIZE = 4,
  parameter int TABLE_SIZE = 64,
  parameter int AGE_PERIOD = 256,
  parameter int HIST_LEN   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            IN_flush,
  input  logic [NUM_PORTS-1:0]            IN_brValid,
  input  logic [NUM_PORTS*31-1:0]         IN_brAddr,
  input  logic [NUM_PORTS*HIST_LEN-1:0]   IN_brHistory,
  input  logic [NUM_PORTS*3-1:0]          IN_brTageID,
  input  logic [NUM_PORTS-1:0]            IN_brTaken,
  input  logic [NUM_PORTS-1:0]            IN_brPred,
  input  logic [NUM_PORTS*5-1:0]          IN_brUseful,
  output logic                            OUT_brStall,
  output logic                            OUT_writeValid,
  output logic [30:0]                     OUT_writeAddr,
  output logic [HIST_LEN-1:0]             OUT_writeHistory,
  output logic [2:0]                      OUT_writeTageID,
  output logic                            OUT_writeTaken,
  output logic                            OUT_writePred,
  output logic [4:0]                      OUT_writeUseful,
  output logic                            OUT_ageValid,
  output logic [$clog2(TABLE_SIZE)-1:0]   OUT_ageIdx
);
  localparam int PTR_W = (QUEUE_SIZE > 1) ? $clog2(QUEUE_SIZE) : 1;
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  localparam int WC_W  = $clog2(AGE_PERIOD);
  localparam int IDX_W = $clog2(TABLE_SIZE);

  typedef struct packed {
    logic [30:0]         addr;
    logic [HIST_LEN-1:0] hist;
    logic [2:0]          tage_id;
    logic                taken;
    logic                pred;
    logic [4:0]          useful;
  } upd_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_AGE = 2'd2} state_t;

  state_t           state_q, state_d;
  upd_t             mem_q [QUEUE_SIZE];
  upd_t             mem_d [QUEUE_SIZE];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, enq_cnt;
  logic [WC_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0] age_idx_q, age_idx_d, age_out_q, age_out_d;
  logic             wvld_q, wvld_d, avld_q, avld_d;
  upd_t             wdat_q, wdat_d;
  logic             stall, enq_ok, issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign stall  = count_q > CNT_W'(QUEUE_SIZE - NUM_PORTS);
  assign enq_ok = !stall && !IN_flush;
  // IDLE with a non-empty queue issues straight away so a write follows its enqueue by one cycle.
  assign issue  = (state_q != S_AGE) && (count_q != '0) && !IN_flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    enq_cnt  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (enq_ok && IN_brValid[p]) begin
        mem_d[wr_ptr_d] = '{addr:    IN_brAddr[31*p +: 31],
                            hist:    IN_brHistory[HIST_LEN*p +: HIST_LEN],
                            tage_id: IN_brTageID[3*p +: 3],
                            taken:   IN_brTaken[p],
                            pred:    IN_brPred[p],
                            useful:  IN_brUseful[5*p +: 5]};
        wr_ptr_d = ptr_inc(wr_ptr_d);
        enq_cnt  = enq_cnt + CNT_W'(1);
      end
    end
    rd_ptr_d = IN_flush ? wr_ptr_q : (issue ? ptr_inc(rd_ptr_q) : rd_ptr_q);
    count_d  = IN_flush ? '0 : count_q + enq_cnt - CNT_W'(issue);
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    age_idx_d = age_idx_q;
    wvld_d    = issue;
    wdat_d    = issue ? mem_q[rd_ptr_q] : wdat_q;
    avld_d    = 1'b0;
    age_out_d = age_out_q;
    case (state_q)
      S_IDLE, S_DRAIN: begin
        if (IN_flush) begin
          state_d = S_IDLE;
        end else if (issue) begin
          if (wr_cnt_q == WC_W'(AGE_PERIOD - 1)) begin
            wr_cnt_d  = '0;
            age_idx_d = '0;
            state_d   = S_AGE;
          end else begin
            wr_cnt_d = wr_cnt_q + WC_W'(1);
            state_d  = (count_d == '0) ? S_IDLE : S_DRAIN;
          end
        end else begin
          state_d = (count_d == '0) ? S_IDLE : S_DRAIN;
        end
      end
      S_AGE: begin
        avld_d    = 1'b1;
        age_out_d = age_idx_q;
        age_idx_d = age_idx_q + IDX_W'(1);
        if (age_idx_q == IDX_W'(TABLE_SIZE - 1)) begin
          state_d = (count_d == '0) ? S_IDLE : S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < QUEUE_SIZE; i++) mem_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_cnt_q  <= '0;
      age_idx_q <= '0;
      age_out_q <= '0;
      wvld_q    <= 1'b0;
      avld_q    <= 1'b0;
      wdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_cnt_q  <= wr_cnt_d;
      age_idx_q <= age_idx_d;
      age_out_q <= age_out_d;
      wvld_q    <= wvld_d;
      avld_q    <= avld_d;
      wdat_q    <= wdat_d;
    end
  end

  assign OUT_brStall      = stall;
  assign OUT_writeValid   = wvld_q;
  assign OUT_writeAddr    = wdat_q.addr;
  assign OUT_writeHistory = wdat_q.hist;
  assign OUT_writeTageID  = wdat_q.tage_id;
  assign OUT_writeTaken   = wdat_q.taken;
  assign OUT_writePred    = wdat_q.pred;
  assign OUT_writeUseful  = wdat_q.useful;
  assign OUT_ageValid     = avld_q;
  assign OUT_ageIdx       = age_out_q;

endmodule

// File: tb/tb_tage_update_scheduler.sv
// Directed bench for tage_update_scheduler with a short aging period (4 writes) and an 8-entry table.
module tb_tage_update_scheduler;
  localparam int NP = 2;
  localparam int HL = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            IN_flush = 1'b0;
  logic [NP-1:0]   IN_brValid = '0;
  logic [NP*31-1:0] IN_brAddr = '0;
  logic [NP*HL-1:0] IN_brHistory = '0;
  logic [NP*3-1:0] IN_brTageID = '0;
  logic [NP-1:0]   IN_brTaken = '0;
  logic [NP-1:0]   IN_brPred = '0;
  logic [NP*5-1:0] IN_brUseful = '0;
  logic            OUT_brStall, OUT_writeValid, OUT_writeTaken, OUT_writePred, OUT_ageValid;
  logic [30:0]     OUT_writeAddr;
  logic [HL-1:0]   OUT_writeHistory;
  logic [2:0]      OUT_writeTageID;
  logic [4:0]      OUT_writeUseful;
  logic [2:0]      OUT_ageIdx;

  int checks = 0;
  int passes = 0;

  tage_update_scheduler #(.NUM_PORTS(NP), .QUEUE_SIZE(4), .TABLE_SIZE(8), .AGE_PERIOD(4), .HIST_LEN(HL)) dut (
    .clk(clk), .rst(rst), .IN_flush(IN_flush), .IN_brValid(IN_brValid), .IN_brAddr(IN_brAddr),
    .IN_brHistory(IN_brHistory), .IN_brTageID(IN_brTageID), .IN_brTaken(IN_brTaken),
    .IN_brPred(IN_brPred), .IN_brUseful(IN_brUseful), .OUT_brStall(OUT_brStall),
    .OUT_writeValid(OUT_writeValid), .OUT_writeAddr(OUT_writeAddr), .OUT_writeHistory(OUT_writeHistory),
    .OUT_writeTageID(OUT_writeTageID), .OUT_writeTaken(OUT_writeTaken), .OUT_writePred(OUT_writePred),
    .OUT_writeUseful(OUT_writeUseful), .OUT_ageValid(OUT_ageValid), .OUT_ageIdx(OUT_ageIdx));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    IN_flush = 1'b0;
    IN_brValid = '0;
    IN_brAddr = '0;
    IN_brHistory = '0;
    IN_brTageID = '0;
    IN_brTaken = '0;
    IN_brPred = '0;
    IN_brUseful = '0;
  endtask

  // Every other field is derived from the address so the write side can be predicted.
  task automatic drive_port(input int p, input logic [30:0] a);
    IN_brValid[p] = 1'b1;
    IN_brAddr[31*p +: 31] = a;
    IN_brHistory[HL*p +: HL] = {1'b1, a};
    IN_brTageID[3*p +: 3] = a[2:0];
    IN_brTaken[p] = a[0];
    IN_brPred[p] = a[1];
    IN_brUseful[5*p +: 5] = a[6:2];
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (OUT_writeValid !== 1'b0 || OUT_ageValid !== 1'b0) $display("FAIL reset_strobes: wv=%b av=%b exp 0 0", OUT_writeValid, OUT_ageValid);
    else passes++;
    checks++;
    if (OUT_brStall !== 1'b0 || OUT_ageIdx !== 3'd0 || OUT_writeAddr !== 31'd0)
      $display("FAIL reset_fields: stall=%b idx=%0d addr=%h exp 0 0 0", OUT_brStall, OUT_ageIdx, OUT_writeAddr);
    else passes++;
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    IN_brValid[0] = 1'b1;
    IN_brAddr[30:0] = 31'h1234;
    IN_brHistory[31:0] = 32'hDEADBEEF;
    IN_brTageID[2:0] = 3'd2;
    IN_brTaken[0] = 1'b1;
    IN_brPred[0] = 1'b0;
    IN_brUseful[4:0] = 5'b10110;
    tick();
    checks++;
    if (OUT_writeValid !== 1'b0) $display("FAIL single_early: wv=%b exp 0", OUT_writeValid);
    else passes++;
    clear_inputs();
    tick();
    checks++;
    if (OUT_writeValid !== 1'b1 || OUT_writeAddr !== 31'h1234 || OUT_writeHistory !== 32'hDEADBEEF ||
        OUT_writeTageID !== 3'd2 || OUT_writeTaken !== 1'b1 || OUT_writePred !== 1'b0 || OUT_writeUseful !== 5'b10110)
      $display("FAIL single_write: wv=%b addr=%h hist=%h id=%0d tk=%b pr=%b us=%b exp 1 1234 deadbeef 2 1 0 10110",
               OUT_writeValid, OUT_writeAddr, OUT_writeHistory, OUT_writeTageID, OUT_writeTaken, OUT_writePred, OUT_writeUseful);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (OUT_writeValid !== 1'b0 || OUT_ageValid !== 1'b0)
        $display("FAIL single_after[%0d]: wv=%b av=%b exp 0 0", k, OUT_writeValid, OUT_ageValid);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_port(0, 31'h100);
    drive_port(1, 31'h101);
    tick();
    checks++;
    if (OUT_brStall !== 1'b0 || OUT_writeValid !== 1'b0) $display("FAIL b2b_c1: stall=%b wv=%b exp 0 0", OUT_brStall, OUT_writeValid);
    else passes++;
    clear_inputs();
    drive_port(0, 31'h102);
    drive_port(1, 31'h103);
    tick();
    checks++;
    if (OUT_brStall !== 1'b1 || OUT_writeValid !== 1'b1 || OUT_writeAddr !== 31'h100)
      $display("FAIL b2b_c2: stall=%b wv=%b addr=%h exp 1 1 100", OUT_brStall, OUT_writeValid, OUT_writeAddr);
    else passes++;
    clear_inputs();
    drive_port(0, 31'h104);
    drive_port(1, 31'h105);
    tick();
    checks++;
    if (OUT_brStall !== 1'b0 || OUT_writeValid !== 1'b1 || OUT_writeAddr !== 31'h101)
      $display("FAIL b2b_c3: stall=%b wv=%b addr=%h exp 0 1 101", OUT_brStall, OUT_writeValid, OUT_writeAddr);
    else passes++;
    clear_inputs();
    for (int k = 4; k <= 14; k++) begin
      tick();
      checks++;
      if (k <= 5) begin
        if (OUT_writeValid !== 1'b1 || OUT_writeAddr !== 31'(32'h102 + k - 4) || OUT_writeTageID !== 3'(k - 2))
          $display("FAIL b2b_drain[%0d]: wv=%b addr=%h id=%0d exp 1 %h %0d", k, OUT_writeValid, OUT_writeAddr,
                   OUT_writeTageID, 32'h102 + k - 4, k - 2);
        else passes++;
      end else begin
        if (OUT_writeValid !== 1'b0) $display("FAIL b2b_dropped[%0d]: wv=%b addr=%h exp no write", k, OUT_writeValid, OUT_writeAddr);
        else passes++;
      end
    end
  endtask

  task automatic test_aging();
    logic        ewv, eav;
    logic [30:0] ea;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      clear_inputs();
      if (k == 1) begin drive_port(0, 31'h200); drive_port(1, 31'h201); end
      if (k == 2) begin drive_port(0, 31'h202); drive_port(1, 31'h203); end
      if (k == 4) begin drive_port(0, 31'h204); drive_port(1, 31'h205); end
      tick();
      ewv = (k >= 2 && k <= 5) || k == 14 || k == 15;
      ea  = (k <= 5) ? 31'(32'h200 + k - 2) : 31'(32'h204 + k - 14);
      eav = (k >= 6 && k <= 13);
      checks++;
      if (OUT_writeValid !== ewv || (ewv && (OUT_writeAddr !== ea || OUT_writeHistory !== {1'b1, ea})) ||
          OUT_ageValid !== eav || (eav && OUT_ageIdx !== 3'(k - 6)))
        $display("FAIL aging[%0d]: wv=%b addr=%h av=%b idx=%0d exp %b %h %b %0d", k, OUT_writeValid, OUT_writeAddr,
                 OUT_ageValid, OUT_ageIdx, ewv, ea, eav, k - 6);
      else passes++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive_port(0, 31'h400);
    drive_port(1, 31'h401);
    tick();
    clear_inputs();
    drive_port(0, 31'h402);
    drive_port(1, 31'h403);
    tick();
    checks++;
    if (OUT_writeValid !== 1'b1 || OUT_writeAddr !== 31'h400 || OUT_brStall !== 1'b1)
      $display("FAIL flush_pre: wv=%b addr=%h stall=%b exp 1 400 1", OUT_writeValid, OUT_writeAddr, OUT_brStall);
    else passes++;
    clear_inputs();
    IN_flush = 1'b1;
    drive_port(0, 31'h404);
    tick();
    clear_inputs();
    checks++;
    if (OUT_writeValid !== 1'b0 || OUT_brStall !== 1'b0)
      $display("FAIL flush_edge: wv=%b stall=%b exp 0 0", OUT_writeValid, OUT_brStall);
    else passes++;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (OUT_writeValid !== 1'b0 || OUT_ageValid !== 1'b0 || OUT_brStall !== 1'b0)
        $display("FAIL flush_after[%0d]: wv=%b av=%b stall=%b exp 0 0 0", k, OUT_writeValid, OUT_ageValid, OUT_brStall);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_age();
    logic        ewv, eav;
    logic [30:0] ea;
    do_reset();
    drive_port(0, 31'h500);
    drive_port(1, 31'h501);
    tick();
    clear_inputs();
    drive_port(0, 31'h502);
    drive_port(1, 31'h503);
    tick();
    clear_inputs();
    for (int k = 3; k <= 9; k++) tick();
    checks++;
    if (OUT_ageValid !== 1'b1 || OUT_ageIdx !== 3'd3) $display("FAIL age_idx3: av=%b idx=%0d exp 1 3", OUT_ageValid, OUT_ageIdx);
    else passes++;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (OUT_writeValid !== 1'b0 || OUT_ageValid !== 1'b0 || OUT_ageIdx !== 3'd0 || OUT_writeAddr !== 31'd0 || OUT_brStall !== 1'b0)
      $display("FAIL rst_async: wv=%b av=%b idx=%0d addr=%h stall=%b exp all 0", OUT_writeValid, OUT_ageValid,
               OUT_ageIdx, OUT_writeAddr, OUT_brStall);
    else passes++;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      clear_inputs();
      if (k == 1) begin drive_port(0, 31'h300); drive_port(1, 31'h301); end
      if (k == 2) drive_port(0, 31'h302);
      if (k == 9) drive_port(1, 31'h303);
      tick();
      ewv = (k >= 2 && k <= 4) || k == 10;
      ea  = (k <= 4) ? 31'(32'h300 + k - 2) : 31'h303;
      eav = (k == 11);
      checks++;
      if (OUT_writeValid !== ewv || (ewv && OUT_writeAddr !== ea) || OUT_ageValid !== eav || (eav && OUT_ageIdx !== 3'd0))
        $display("FAIL post_rst[%0d]: wv=%b addr=%h av=%b idx=%0d exp %b %h %b 0", k, OUT_writeValid, OUT_writeAddr,
                 OUT_ageValid, OUT_ageIdx, ewv, ea, eav);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_aging();
    test_flush();
    test_reset_mid_age();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
